// File: rtl/ro_slot_deser.sv
// ro_slot_deser: captures the shared tri-stated readout line once per enabled
// clock edge, tags each sample with the channel whose gray-counter bit toggled
// in that slot, and queues {channel, bit} in a small first-word-fall-through FIFO.
// Optional feature macro: RO_SLOT_DESER_CHMASK_EN (adds chan_mask input that
// filters channels before the FIFO; masked samples never count as overflow).
module ro_slot_deser #(
  parameter int NCH   = 16,
  parameter int CW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk_ext,
  input  logic                       reset,
  input  logic                       en,
`ifdef RO_SLOT_DESER_CHMASK_EN
  input  logic [NCH-1:0]             chan_mask,
`endif
  input  logic                       mux_in,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [CW-1:0]              rd_chan,
  output logic                       rd_bit,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [NCH-1:0] k_q, k_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [LW-1:0]  lvl_q, lvl_d;
  logic           ovf_q, ovf_d;
  logic [CW:0]    mem_q [DEPTH];
  logic [CW:0]    mem_d [DEPTH];

  logic [NCH-1:0] kp1;
  logic [CW-1:0]  slot_c;
  logic           slot_live;
  logic           full;
  logic           pop;
  logic           push_ok;
  logic [CW:0]    head;

  assign full       = (lvl_q == LW'(DEPTH));
  assign rd_valid   = (lvl_q != '0);
  assign head       = mem_q[rd_q];
  assign rd_chan    = rd_valid ? head[CW:1] : '0;
  assign rd_bit     = rd_valid ? head[0] : 1'b0;
  assign fifo_level = lvl_q;
  assign overflow   = ovf_q;

  // Slot decode (trailing-zero count of k+1) and FIFO push/pop bookkeeping.
  always_comb begin
    k_d     = k_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    lvl_d   = lvl_q;
    ovf_d   = ovf_q;
    mem_d   = mem_q;
    kp1     = k_q + 1'b1;
    slot_c  = '0;
    // Scan from the top so the lowest set bit of k+1 is the last one written.
    for (int unsigned i = 0; i < NCH; i++) begin
      if (kp1[NCH-1-i]) slot_c = CW'(NCH-1-i);
    end
`ifdef RO_SLOT_DESER_CHMASK_EN
    slot_live = en && (kp1 != '0) && chan_mask[slot_c];
`else
    slot_live = en && (kp1 != '0);
`endif
    pop     = rd_valid && rd_ready;
    push_ok = slot_live && (!full || pop);
    if (en) k_d = kp1;
    if (slot_live && full && !pop) ovf_d = 1'b1;
    if (push_ok) begin
      mem_d[wr_q] = {slot_c, mux_in};
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    lvl_d = lvl_q + LW'(push_ok) - LW'(pop);
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk_ext) begin
    if (reset) begin
      k_q   <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      k_q   <= k_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_ro_slot_deser.sv
// Scoreboard bench for ro_slot_deser: the driver applies stimulus and updates a
// queue-based reference model after each edge; the monitor compares DUT state
// and pops expected entries whenever a transfer is presented.
module tb_ro_slot_deser;
  localparam int NCH   = 4;
  localparam int CW    = 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic           clk_ext = 1'b0;
  logic           reset = 1'b1;
  logic           en = 1'b0;
  logic           mux_in = 1'b0;
  logic           rd_ready = 1'b0;
  logic [NCH-1:0] chan_mask = '1;
  logic           rd_valid;
  logic [CW-1:0]  rd_chan;
  logic           rd_bit;
  logic [LW-1:0]  fifo_level;
  logic           overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  int exp_q[$];     // entries encoded as chan*2 + bit
  int mk = 0;       // reference slot counter
  bit exp_ovf = 0;
  bit post_reset = 0;

  ro_slot_deser #(.NCH(NCH), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk_ext    (clk_ext),
    .reset      (reset),
    .en         (en),
`ifdef RO_SLOT_DESER_CHMASK_EN
    .chan_mask  (chan_mask),
`endif
    .mux_in     (mux_in),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_chan    (rd_chan),
    .rd_bit     (rd_bit),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk_ext = ~clk_ext;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int ctz(input int v);
    int n = 0;
    while (((v >> n) & 1) == 0) n++;
    return n;
  endfunction

  // Reference effect of the edge that just happened, using the inputs held across it.
  task automatic model_edge();
    int kp1;
    int c;
    if (reset) begin
      exp_q.delete();
      mk = 0;
      exp_ovf = 0;
      post_reset = 1;
      return;
    end
    if (!en) return;
    kp1 = (mk + 1) % (1 << NCH);
    mk = kp1;
    if (kp1 == 0) return;
    c = ctz(kp1);
`ifdef RO_SLOT_DESER_CHMASK_EN
    if (!chan_mask[c]) return;
`endif
    // Monitor has already removed an entry it saw consumed, so size reflects room.
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(c * 2 + int'(mux_in));
      post_reset = 0;
    end else begin
      exp_ovf = 1;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic m, input logic rr);
    reset = r; en = e; mux_in = m; rd_ready = rr;
    @(posedge clk_ext);
    #1;
    model_edge();
  endtask

  // Monitor: mid-cycle comparison and scoreboard pop on each presented transfer.
  initial begin
    int e;
    forever begin
      @(negedge clk_ext);
      chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
      if (post_reset) begin
        chk("rd_chan_reset", 32'(rd_chan), 32'd0);
        chk("rd_bit_reset", 32'(rd_bit), 32'd0);
      end
      if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_entry", 32'(rd_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_chan", 32'(rd_chan), 32'(e / 2));
          chk("rd_bit", 32'(rd_bit), 32'(e % 2));
          n_pops++;
        end
      end
    end
  end

  initial begin
    int p0;
    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_valid", 32'(rd_valid), 32'd0);

    // Channel order 0,1,0,2,0,1,0,3 then the idle slot at k+1=16
    p0 = n_pops;
    for (int i = 0; i < 16; i++) step(0, 1, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("wrap_entries", 32'(n_pops - p0), 32'd15);
    // After wrap the next slot is k+1=1 again -> channel 0
    step(0, 1, 0, 0);
    chk("wrap_chan0", 32'(rd_chan), 32'd0);

    // Overflow: five pushes with no consumer
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(rd_chan), 32'd0);
    step(0, 0, 0, 0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous push and pop
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    chk("full_pp_level", 32'(fifo_level), 32'd4);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    chk("full_pp_head", 32'(rd_chan), 32'd1);

    // Reset mid-operation
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    chk("mid_level", 32'(fifo_level), 32'd3);
    step(1, 1, 1, 0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    step(0, 1, 1, 0);
    chk("mid_first_valid", 32'(rd_valid), 32'd1);
    chk("mid_first_chan", 32'(rd_chan), 32'd0);

`ifdef RO_SLOT_DESER_CHMASK_EN
    // Masking channel 0: expect 1,2,1,3 only
    step(1, 0, 0, 1);
    chan_mask = 4'b1110;
    p0 = n_pops;
    for (int i = 0; i < 8; i++) step(0, 1, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("mask_entries", 32'(n_pops - p0), 32'd4);
    chk("mask_ovf", 32'(overflow), 32'd0);
`endif

    // Randomized traffic
    step(1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
`ifdef RO_SLOT_DESER_CHMASK_EN
      if ($urandom_range(0, 49) == 0) chan_mask = NCH'($urandom);
`endif
      step(logic'($urandom_range(0, 149) == 0),
           logic'($urandom_range(0, 9) < 8),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 7 : 3)));
    end

    // Drain
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    chk("drain_level", 32'(fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
